// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I pipeline constants
package rv32_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage : rv32_pkg

// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - IF/ID decoupling queue of {pc, instr, exception} bundles
module fetch_decode_buffer
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN_P = XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN_P-1:0]          in_pc,
  input  logic [XLEN_P-1:0]          in_instr,
  input  logic                       in_exception,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN_P-1:0]          out_pc,
  output logic [XLEN_P-1:0]          out_instr,
  output logic                       out_exception,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN_P-1:0] r_pc    [DEPTH];
  logic [XLEN_P-1:0] r_instr [DEPTH];
  logic              r_exc   [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_exc_hold;

  logic w_push;
  logic w_pop;
  logic w_store_exc;
  logic w_valid;

  assign w_valid     = (r_count != '0);
  assign in_ready    = (r_count != FULL_COUNT) && !r_exc_hold && !flush;
  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_valid && out_ready;
  // A misaligned fetch address becomes an exception entry regardless of fetch's flag.
  assign w_store_exc = in_exception || (in_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail]    <= in_pc;
      r_instr[r_tail] <= in_instr;
      r_exc[r_tail]   <= w_store_exc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_exc_hold <= 1'b0;
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_exc_hold <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      // Only one exception entry can be resident, so set and clear never coincide.
      if (w_push && w_store_exc) begin
        r_exc_hold <= 1'b1;
      end else if (w_pop && r_exc[r_head]) begin
        r_exc_hold <= 1'b0;
      end
    end
  end

  assign out_valid     = w_valid;
  assign out_pc        = w_valid ? r_pc[r_head]    : '0;
  assign out_instr     = w_valid ? r_instr[r_head] : XLEN_P'(NOP_INSTR);
  assign out_exception = w_valid ? r_exc[r_head]   : 1'b0;
  assign count         = r_count;

endmodule : fetch_decode_buffer
